// File: rtl/text_pos_gen.sv
// text_pos_gen: character-cell position and display-RAM address generator for text-mode video.
// Walks pixel -> column -> scanline -> row -> frame on each enabled pixel, keeps a running
// row base so no multiplier is needed, and issues an early fetch for the next character.
// Optional cursor detection with blink is built only when TEXT_POS_CURSOR_EN is defined;
// otherwise cursor_hit is tied low and no blink counter or comparator exists.
module text_pos_gen #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 25,
    parameter int unsigned CHAR_W     = 9,
    parameter int unsigned CHAR_H     = 14,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned FETCH_LEAD = 4,
    parameter int unsigned BLINK_DIV  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              restart,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic [3:0]        cursor_start,
    input  logic [3:0]        cursor_end,
    output logic [6:0]        col,
    output logic [4:0]        row,
    output logic [3:0]        char_pixel,
    output logic [3:0]        char_row,
    output logic [ADDR_W-1:0] addr,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              eol,
    output logic              eof,
    output logic              cursor_hit
);

    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned PIX_W  = 4;
    localparam int unsigned LINE_W = 4;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CHAR_W - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(CHAR_H - 1);
    localparam logic [PIX_W-1:0]  PIX_FETCH = PIX_W'(CHAR_W - 1 - FETCH_LEAD);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

    // Elaboration-time guard against geometries the counters or fetch timing cannot represent
    if (FETCH_LEAD < 1 || FETCH_LEAD >= CHAR_W) begin : g_bad_fetch_lead
        $error("text_pos_gen: FETCH_LEAD must lie in 1..CHAR_W-1");
    end
    if (COLS < 1 || COLS > 128 || ROWS < 1 || ROWS > 32) begin : g_bad_grid
        $error("text_pos_gen: COLS must be 1..128 and ROWS 1..32");
    end
    if (CHAR_W < 2 || CHAR_W > 16 || CHAR_H < 1 || CHAR_H > 16) begin : g_bad_cell
        $error("text_pos_gen: CHAR_W must be 2..16 and CHAR_H 1..16");
    end

    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic              pix_last_c;
    logic              col_last_c;
    logic              line_last_c;
    logic              row_last_c;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] fetch_next_c;
    logic              eol_c;
    logic              eof_c;
    logic              fetch_req_c;

    // Last-position flags shared by the advance logic, strobes and fetch address
    always_comb begin
        pix_last_c  = (pix_q == PIX_LAST);
        col_last_c  = (col_q == COL_LAST);
        line_last_c = (line_q == LINE_LAST);
        row_last_c  = (row_q == ROW_LAST);
    end

    // Nested counter advance; restart wins over enable and reloads the scroll base
    always_comb begin
        pix_d      = pix_q;
        col_d      = col_q;
        line_d     = line_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (restart) begin
            pix_d      = '0;
            col_d      = '0;
            line_d     = '0;
            row_d      = '0;
            row_base_d = start_addr;
        end else if (enable) begin
            if (!pix_last_c) begin
                pix_d = pix_q + PIX_W'(1);
            end else begin
                pix_d = '0;
                if (!col_last_c) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d = '0;
                    if (!line_last_c) begin
                        // Next scanline of the same text row: base unchanged
                        line_d = line_q + LINE_W'(1);
                    end else begin
                        line_d = '0;
                        if (!row_last_c) begin
                            row_d      = row_q + ROW_W'(1);
                            row_base_d = row_base_q + ROW_STEP;
                        end else begin
                            row_d      = '0;
                            row_base_d = start_addr;
                        end
                    end
                end
            end
        end
    end

    // Position and row-base state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q      <= '0;
            col_q      <= '0;
            line_q     <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            pix_q      <= pix_d;
            col_q      <= col_d;
            line_q     <= line_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

    // Current cell address, next-cell fetch address and enable-gated strobes
    always_comb begin
        addr_c = row_base_q + ADDR_W'(col_q);
        if (!col_last_c) begin
            fetch_next_c = addr_c + ADDR_W'(1);
        end else if (!line_last_c) begin
            fetch_next_c = row_base_q;
        end else if (!row_last_c) begin
            fetch_next_c = row_base_q + ROW_STEP;
        end else begin
            fetch_next_c = start_addr;
        end
        eol_c       = enable & pix_last_c & col_last_c;
        eof_c       = eol_c & line_last_c & row_last_c;
        fetch_req_c = enable & (pix_q == PIX_FETCH);
    end

    assign col        = COL_W'(col_q);
    assign row        = ROW_W'(row_q);
    assign char_pixel = pix_q;
    assign char_row   = line_q;
    assign addr       = addr_c;
    assign eol        = eol_c;
    assign eof        = eof_c;
    assign fetch_req  = fetch_req_c;
    assign fetch_addr = fetch_req_c ? fetch_next_c : '0;

`ifdef TEXT_POS_CURSOR_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;
    logic               frame_wrap_c;

    // Count frame wraps and flip blink phase every BLINK_DIV of them
    always_comb begin
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        frame_wrap_c = eof_c & ~restart;
        if (frame_wrap_c) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Blink state register; cursor starts visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Cursor cell and scanline window match; an inverted window never matches
    assign cursor_hit = (addr_c == cursor_addr) &&
                        (line_q >= cursor_start) &&
                        (line_q <= cursor_end) &&
                        blink_on_q;
`else
    logic unused_cursor_c;

    assign cursor_hit      = 1'b0;
    assign unused_cursor_c = ^{cursor_addr, cursor_start, cursor_end, 32'(BLINK_DIV)};
`endif

endmodule

// File: tb/tb_text_pos_gen.sv
// tb_text_pos_gen: scoreboard bench for text_pos_gen (default build, cursor disabled).
// Instance u_big uses the default geometry; u_small uses a tiny geometry so a whole
// frame, including the single eof and the wrap back to the scroll base, fits in a short run.
module tb_text_pos_gen;

    typedef struct {
        int sel;
        int col;
        int row;
        int cp;
        int cr;
        int addr;
        bit freq;
        int fa;
        bit eol;
        bit eof;
        bit chk_fa;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic en0, rs0, en1, rs1;
    logic [10:0] sa0, ca0;
    logic [5:0]  sa1, ca1;
    logic [3:0]  cs, ce;

    logic [6:0]  col0, col1;
    logic [4:0]  row0, row1;
    logic [3:0]  cp0, cp1, cr0, cr1;
    logic [10:0] addr0, fa0;
    logic [5:0]  addr1, fa1;
    logic        freq0, freq1, eol0, eol1, eof0, eof1, hit0, hit1;

    exp_t sbq[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nn[2];
    int   base[2];
    int   eof_cnt1 = 0;

    always #5 clk = ~clk;

    text_pos_gen u_big (
        .clk(clk), .rst(rst), .enable(en0), .restart(rs0),
        .start_addr(sa0), .cursor_addr(ca0), .cursor_start(cs), .cursor_end(ce),
        .col(col0), .row(row0), .char_pixel(cp0), .char_row(cr0),
        .addr(addr0), .fetch_req(freq0), .fetch_addr(fa0),
        .eol(eol0), .eof(eof0), .cursor_hit(hit0)
    );

    text_pos_gen #(
        .COLS(4), .ROWS(12), .CHAR_W(3), .CHAR_H(2), .ADDR_W(6), .FETCH_LEAD(1), .BLINK_DIV(2)
    ) u_small (
        .clk(clk), .rst(rst), .enable(en1), .restart(rs1),
        .start_addr(sa1), .cursor_addr(ca1), .cursor_start(cs), .cursor_end(ce),
        .col(col1), .row(row1), .char_pixel(cp1), .char_row(cr1),
        .addr(addr1), .fetch_req(freq1), .fetch_addr(fa1),
        .eol(eol1), .eof(eof1), .cursor_hit(hit1)
    );

    // Expected outputs after n enabled pixels from a frame start with scroll base b
    function automatic exp_t model(input int sel, input int n, input int b, input bit en);
        int cols, rows, cw, ch, aw, lead, f, m, msk;
        exp_t e;
        if (sel == 0) begin
            cols = 80; rows = 25; cw = 9; ch = 14; aw = 11; lead = 4;
        end else begin
            cols = 4; rows = 12; cw = 3; ch = 2; aw = 6; lead = 1;
        end
        msk    = (1 << aw) - 1;
        f      = cols * rows * cw * ch;
        m      = n % f;
        e.sel  = sel;
        e.cp   = m % cw;
        e.col  = (m / cw) % cols;
        e.cr   = (m / (cw * cols)) % ch;
        e.row  = m / (cw * cols * ch);
        e.addr = (b + e.row * cols + e.col) & msk;
        e.eol  = en && (e.col == cols - 1) && (e.cp == cw - 1);
        e.eof  = e.eol && (e.cr == ch - 1) && (e.row == rows - 1);
        e.freq = en && (e.cp == cw - 1 - lead);
        e.chk_fa = e.freq;
        if (e.col < cols - 1)      e.fa = (e.addr + 1) & msk;
        else if (e.cr < ch - 1)    e.fa = (b + e.row * cols) & msk;
        else if (e.row < rows - 1) e.fa = (b + (e.row + 1) * cols) & msk;
        else                       e.fa = b & msk;
        return e;
    endfunction

    function automatic exp_t mk(input int sel, input int c, input int r, input int p, input int l,
                                input int a, input bit fq, input int fa, input bit el, input bit ef);
        exp_t e;
        e.sel = sel; e.col = c; e.row = r; e.cp = p; e.cr = l; e.addr = a;
        e.freq = fq; e.fa = fa; e.eol = el; e.eof = ef; e.chk_fa = fq;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per cycle and compare against the selected instance
    always @(negedge clk) begin
        if (eof1) eof_cnt1++;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            if (me.sel == 0) begin
                chk("col0", int'(col0), me.col);
                chk("row0", int'(row0), me.row);
                chk("char_pixel0", int'(cp0), me.cp);
                chk("char_row0", int'(cr0), me.cr);
                chk("addr0", int'(addr0), me.addr);
                chk("fetch_req0", int'(freq0), int'(me.freq));
                chk("eol0", int'(eol0), int'(me.eol));
                chk("eof0", int'(eof0), int'(me.eof));
                chk("cursor_hit0", int'(hit0), 0);
                if (me.chk_fa) chk("fetch_addr0", int'(fa0), me.fa);
            end else begin
                chk("col1", int'(col1), me.col);
                chk("row1", int'(row1), me.row);
                chk("char_pixel1", int'(cp1), me.cp);
                chk("char_row1", int'(cr1), me.cr);
                chk("addr1", int'(addr1), me.addr);
                chk("fetch_req1", int'(freq1), int'(me.freq));
                chk("eol1", int'(eol1), int'(me.eol));
                chk("eof1", int'(eof1), int'(me.eof));
                if (me.chk_fa) chk("fetch_addr1", int'(fa1), me.fa);
            end
        end
    end

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en0 = v;
        else          en1 = v;
    endtask

    task automatic adv(input int sel, input bit en, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            set_en(sel, en);
            sbq.push_back(model(sel, nn[sel], base[sel], en));
            @(posedge clk);
            #1;
            if (en) nn[sel]++;
        end
    endtask

    task automatic adv_hand(input exp_t e);
        set_en(e.sel, 1'b1);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        nn[e.sel]++;
    endtask

    task automatic do_restart(input int sel, input int start, input bit en);
        set_en(sel, en);
        if (sel == 0) begin rs0 = 1'b1; sa0 = 11'(start); end
        else          begin rs1 = 1'b1; sa1 = 6'(start); end
        @(posedge clk);
        #1;
        rs0 = 1'b0;
        rs1 = 1'b0;
        set_en(sel, 1'b0);
        nn[sel]   = 0;
        base[sel] = start;
    endtask

    task automatic push_reset(input int sel);
        exp_t e;
        e = mk(sel, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        e.chk_fa = 1'b1;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        en0 = 1'b0; rs0 = 1'b0; en1 = 1'b0; rs1 = 1'b0;
        sa0 = '0; sa1 = '0; ca0 = 11'd5; ca1 = 6'd5; cs = 4'd0; ce = 4'd15;
        nn[0] = 0; nn[1] = 0; base[0] = 0; base[1] = 0;

        // Reset state on both instances
        @(posedge clk); #1;
        push_reset(0);
        @(posedge clk); #1;
        push_reset(1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Scroll base near the top of the address space wraps at column 16
        do_restart(0, 11'h7F0, 1'b0);
        adv_hand(mk(0, 0, 0, 0, 0, 11'h7F0, 1'b0, 0, 1'b0, 1'b0));
        adv(0, 1'b1, 143);
        adv_hand(mk(0, 16, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0));
        adv(0, 1'b1, 575);

        // Row-end fetch on row 3: same row at scanline 5, next row at scanline 13
        do_restart(0, 0, 1'b0);
        adv(0, 1'b1, 34555);
        adv_hand(mk(0, 79, 3, 4, 5, 319, 1'b1, 240, 1'b0, 1'b0));
        adv(0, 1'b1, 5759);
        adv_hand(mk(0, 79, 3, 4, 13, 319, 1'b1, 320, 1'b0, 1'b0));
        adv(0, 1'b1, 4);

        // Enable toggling: state holds and strobes stay low on idle cycles
        for (int i = 0; i < 100; i++) begin
            adv(0, 1'b1, 1);
            adv(0, 1'b0, 1);
        end

        // Restart mid-frame with enable high: counters clear and base loads
        do_restart(0, 160, 1'b1);
        adv_hand(mk(0, 0, 0, 0, 0, 160, 1'b0, 0, 1'b0, 1'b0));
        adv(0, 1'b1, 50);

        // Asynchronous reset mid-line clears outputs before the next clock edge
        en0 = 1'b0;
        rst = 1'b1;
        push_reset(0);
        @(posedge clk); #1;
        push_reset(1);
        @(posedge clk); #1;
        rst = 1'b0;
        nn[0] = 0; nn[1] = 0; base[0] = 0; base[1] = 0;
        adv(0, 1'b1, 20);

        // Whole small frame: single eof on the last pixel, then wrap to base
        adv(1, 1'b1, 287);
        adv_hand(mk(1, 3, 11, 2, 1, 47, 1'b0, 0, 1'b1, 1'b1));
        adv_hand(mk(1, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0));
        adv(1, 1'b1, 5);
        en1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("eof_count", eof_cnt1, 1);
        chk("scoreboard_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
